bg_tile_renderer: RTL and testbench
===================================

BG_TILE_RENDERER -- requirements
Module: bg_tile_renderer

Interface
REQ-001 SHALL use clock and reset exactly as follows: reset reset, synchronous, active-high; clock clk.
REQ-002 Parameters:
  - TILE_COLS, default 40, tiles per row.
  - TILE_ROWS, default 30, tiles per column.
  - KEY_COLOR, default 12'hF0F, transparent sheet colour.
  - LATENCY, fixed 5, not overridable.
REQ-003 Ports, clock and reset first:
  - clk  in  1  system clock
  - reset  in  1  synchronous reset
  - video_on  in  1  active-area flag from vga_sync
  - x  in  10  current pixel column
  - y  in  10  current pixel row
  - bg_x_offset  in  4  fine scroll from game_engine
  - bg_ram_addr  out  16  background RAM read address, port B
  - bg_ram_data  in  32  RAM read word, 1-cycle synchronous latency
  - sheet_addr  out  14  tile-sheet ROM address
  - sheet_data  in  12  RGB444 from ROM, 1-cycle synchronous latency
  - rgb  out  12  background pixel colour
  - bg_visible  out  1  pixel is opaque background
  - pixel_valid  out  1  rgb/bg_visible correspond to an active pixel

Function
REQ-004 SHALL decode a RAM word as follows; bits [31:9] are ignored:
  - [2:0] tile_col
  - [5:3] tile_row
  - [6] x_flip
  - [7] y_flip
  - [8] enable
REQ-005 SHALL hold a line_offset register; at the cycle where x==640, load it from bg_x_offset; it applies to the whole following line, so there is no mid-line tearing.
REQ-006 Stage 0, cycle T:
  - sx = x + line_offset, 11-bit.
  - col = sx>>4; if col >= TILE_COLS, col = col - TILE_COLS (single wrap).
  - row = y>>4.
REQ-007 SHALL register bg_ram_addr = row*TILE_COLS + col at T+1, with the upper bits zero-extended.
REQ-008 SHALL delay video_on, px = sx[3:0] and py = y[3:0] alongside the pipeline, so they align with the RAM data at T+2 and the sheet data at T+4.
REQ-009 At T+3, SHALL register sheet_addr = {tile_row, py', tile_col, px'}:
  - px' = x_flip ? 15-px : px.
  - py' = y_flip ? 15-py : py.
REQ-010 SHALL delay the enable bit with the pipeline so it aligns with sheet_data at T+4.
REQ-011 At T+5, SHALL register the outputs as follows:
  - pixel_valid = delayed video_on.
  - bg_visible = pixel_valid & enable & (sheet_data != KEY_COLOR).
  - rgb = bg_visible ? sheet_data : 12'h000.
REQ-012 Total input-to-output latency SHALL be exactly 5 clk, every cycle, with no stall and no bubble.
REQ-013 When video_on==0, the address outputs SHALL still update, and outputs at T+5 SHALL show pixel_valid=0, bg_visible=0, rgb=0.
REQ-014 y >= 480 with video_on==1 is illegal input; behaviour is don't-care except that no X propagates.
REQ-015 The block SHALL never write RAM or ROM; it is a read-only consumer of game_engine's bg RAM.
REQ-016 The address path (bg_ram_addr, sheet_addr) SHALL be purely registered; rgb SHALL carry no combinational path from any input.

Reset
REQ-017 While reset is high, SHALL hold:
  - line_offset = 0
  - bg_ram_addr = 0
  - sheet_addr = 0
  - rgb = 0
  - bg_visible = 0
  - pixel_valid = 0
  - all pipeline valid/enable bits = 0
REQ-018 On reset deassertion, SHALL produce the first valid output 5 cycles after the first sampled video_on==1 and never earlier.
REQ-019 Reset asserted mid-line SHALL flush all in-flight pixels; no stale pixel_valid=1 may appear after reset.

Verification
REQ-020 Bench SHALL cover:
  - V1 basic fetch: line_offset=0, x=37, y=100, video_on=1 -> bg_ram_addr=6*40+2=242 at T+1. RAM returns {enable=1, x_flip=0, y_flip=0, row=6, col=1}. At T+3, sheet_addr = {3'd6, 4'd4, 3'd1, 4'd5}. At T+5, rgb = the ROM word, pixel_valid=1.
  - V2 scroll wrap: bg_x_offset=15 latched at x=640 of the previous line; next line x=630, sx=645, col=40 -> wraps to 0; bg_ram_addr = row*40 + 0.
  - V3 flips: RAM word with x_flip=1, y_flip=1, px=2, py=3 -> sheet_addr low nibble = 13, py' = 12.
  - V4 transparency and disable: sheet_data=12'hF0F -> bg_visible=0, rgb=0, pixel_valid=1. enable=0 with any sheet_data gives the same result.
  - V5 blanking and latency: video_on 1->0 at cycle N -> pixel_valid falls at N+5 exactly. Also check that an offset change mid-line (x=300) does not alter sx until the line after x==640.
  - V6 reset mid-line: assert reset for 1 cycle at x=200 -> all outputs 0 next cycle. pixel_valid stays 0 until 5 cycles after resumed video_on.

Source files
------------

// File: rtl/bg_tile_renderer.sv
// Background tile renderer.
// Turns the current pixel position into a background colour. It reads the
// tile map from the background RAM and then the tile sheet from the ROM.
// The pipeline is fixed at 5 cycles and never stalls or inserts a bubble.
// Both memories have 1-cycle synchronous read latency.
// There is no handshake: one pixel enters per clock, and one result
// leaves per clock, 5 cycles later.
module bg_tile_renderer #(
    parameter int          TILE_COLS = 40,
    parameter int          TILE_ROWS = 30,
    parameter logic [11:0] KEY_COLOR = 12'hF0F,
    localparam int         LATENCY   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [3:0]  bg_x_offset,
    output logic [15:0] bg_ram_addr,
    input  logic [31:0] bg_ram_data,
    output logic [13:0] sheet_addr,
    input  logic [11:0] sheet_data,
    output logic [11:0] rgb,
    output logic        bg_visible,
    output logic        pixel_valid
);

    // Fine scroll, held for a whole line so the picture never tears mid-line.
    logic [3:0]  line_offset;

    // Stage 0 (combinational from the pixel position).
    logic [10:0] sx;
    logic [6:0]  col_raw;
    logic [6:0]  col;
    logic [5:0]  row;
    logic [15:0] addr_next;

    // Pipeline registers: px/py ride along until the RAM word arrives.
    logic [3:0]  px1, py1, px2, py2;
    logic        en3, en4;
    // video_on delay line; bit i holds the flag for stage T+i+1.
    logic [LATENCY-2:0] vo_pipe;

    // Fields of the RAM word, valid at T+2.
    logic [2:0]  tile_col;
    logic [2:0]  tile_row;
    logic        x_flip;
    logic        y_flip;
    logic        tile_en;
    logic [3:0]  px_f;
    logic [3:0]  py_f;
    logic        opaque;
    logic        unused_ram_bits;

    assign unused_ram_bits = ^bg_ram_data[31:9];

    // Scrolled column with a single wrap, and the map address.
    // Rows beyond the map only occur in vertical blanking; they read row 0.
    always_comb begin
        sx      = {1'b0, x} + {7'd0, line_offset};
        col_raw = sx[10:4];
        col     = col_raw;
        if (int'(col_raw) >= TILE_COLS) begin
            col = 7'(int'(col_raw) - TILE_COLS);
        end
        row = y[9:4];
        if (int'(row) >= TILE_ROWS) begin
            row = '0;
        end
        addr_next = 16'(int'(row) * TILE_COLS + int'(col));
    end

    // Decode the tile word and apply flips (15 - p is the bitwise inverse).
    always_comb begin
        tile_col = bg_ram_data[2:0];
        tile_row = bg_ram_data[5:3];
        x_flip   = bg_ram_data[6];
        y_flip   = bg_ram_data[7];
        tile_en  = bg_ram_data[8];
        px_f     = x_flip ? ~px2 : px2;
        py_f     = y_flip ? ~py2 : py2;
        opaque   = vo_pipe[LATENCY-2] & en4 & (sheet_data != KEY_COLOR);
    end

    // Latch the fine scroll once per line, at the first pixel past the active area.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_offset <= '0;
        end else if (x == 10'd640) begin
            line_offset <= bg_x_offset;
        end
    end

    // Five-stage registered pipeline from pixel position to colour.
    always_ff @(posedge clk) begin
        if (reset) begin
            bg_ram_addr <= '0;
            px1         <= '0;
            py1         <= '0;
            px2         <= '0;
            py2         <= '0;
            sheet_addr  <= '0;
            en3         <= 1'b0;
            en4         <= 1'b0;
            vo_pipe     <= '0;
            rgb         <= '0;
            bg_visible  <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            // T+1: map address; RAM word comes back at T+2.
            bg_ram_addr <= addr_next;
            px1         <= sx[3:0];
            py1         <= y[3:0];
            // T+2: align pixel offsets with the RAM word.
            px2         <= px1;
            py2         <= py1;
            // T+3: sheet address; ROM word comes back at T+4.
            sheet_addr  <= {tile_row, py_f, tile_col, px_f};
            en3         <= tile_en;
            // T+4: align enable with the ROM word.
            en4         <= en3;
            vo_pipe     <= {vo_pipe[LATENCY-3:0], video_on};
            // T+5: final pixel.
            pixel_valid <= vo_pipe[LATENCY-2];
            bg_visible  <= opaque;
            rgb         <= opaque ? sheet_data : 12'h000;
        end
    end

endmodule

// File: tb/tb_bg_tile_renderer.sv
// Directed bench for bg_tile_renderer with 1-cycle RAM/ROM models.
module tb_bg_tile_renderer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_on = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [3:0]  bg_x_offset = '0;
    logic [15:0] bg_ram_addr;
    logic [31:0] bg_ram_data = '0;
    logic [13:0] sheet_addr;
    logic [11:0] sheet_data = '0;
    logic [11:0] rgb;
    logic        bg_visible;
    logic        pixel_valid;

    logic [31:0] ram [0:2047];
    logic [11:0] rom [0:16383];

    int tests = 0;
    int failed = 0;

    bg_tile_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .video_on    (video_on),
        .x           (x),
        .y           (y),
        .bg_x_offset (bg_x_offset),
        .bg_ram_addr (bg_ram_addr),
        .bg_ram_data (bg_ram_data),
        .sheet_addr  (sheet_addr),
        .sheet_data  (sheet_data),
        .rgb         (rgb),
        .bg_visible  (bg_visible),
        .pixel_valid (pixel_valid)
    );

    // Clock and synchronous memory models.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bg_ram_data <= ram[bg_ram_addr[10:0]];
        sheet_data  <= rom[sheet_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int xx, input int yy);
        video_on = v;
        x = 10'(xx);
        y = 10'(yy);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
        for (int i = 0; i < 16384; i++) rom[i] = 12'(i) ^ 12'h0A5;
        ram[242] = 32'h131;   // en, row 6, col 1
        ram[240] = 32'h100;   // en, row 0, col 0
        ram[241] = 32'h1D5;   // en, y_flip, x_flip, row 2, col 5
        ram[43]  = 32'h100;   // en, row 0, col 0
        ram[44]  = 32'h00A;   // disabled, row 1, col 2
        rom[14'h3215] = 12'h7A3;
        rom[14'h0205] = 12'h456;
        rom[14'h165D] = 12'h123;
        rom[14'h0202] = 12'hF0F;
        rom[14'h0A22] = 12'hABC;

        // Reset state.
        drive(0, 0, 0);
        tick(); tick(); tick();
        chk("rst_addr", 32'(bg_ram_addr), 32'h0);
        chk("rst_sheet", 32'(sheet_addr), 32'h0);
        chk("rst_rgb", 32'(rgb), 32'h0);
        chk("rst_vis", 32'(bg_visible), 32'h0);
        chk("rst_pv", 32'(pixel_valid), 32'h0);
        reset = 1'b0;

        // V1 basic fetch.
        drive(1, 37, 100); tick();
        chk("v1_addr", 32'(bg_ram_addr), 32'd242);
        drive(0, 0, 0); tick(); tick();
        chk("v1_sheet", 32'(sheet_addr), 32'({3'd6, 4'd4, 3'd1, 4'd5}));
        tick(); tick();
        chk("v1_rgb", 32'(rgb), 32'h7A3);
        chk("v1_vis", 32'(bg_visible), 32'h1);
        chk("v1_pv", 32'(pixel_valid), 32'h1);
        tick();
        chk("v1_pv_after", 32'(pixel_valid), 32'h0);

        // V2 scroll wrap, then V3 flips back to back.
        drive(0, 640, 99); bg_x_offset = 4'd15; tick();
        bg_x_offset = 4'd0;
        drive(1, 630, 100); tick();
        chk("v2_addr", 32'(bg_ram_addr), 32'd240);
        drive(1, 3, 99); tick();
        chk("v3_addr", 32'(bg_ram_addr), 32'd241);
        drive(0, 0, 0); tick();
        chk("v2_sheet", 32'(sheet_addr), 32'({3'd0, 4'd4, 3'd0, 4'd5}));
        tick();
        chk("v3_sheet", 32'(sheet_addr), 32'({3'd2, 4'd12, 3'd5, 4'd13}));
        tick();
        chk("v2_rgb", 32'(rgb), 32'h456);
        tick();
        chk("v3_rgb", 32'(rgb), 32'h123);
        chk("v3_vis", 32'(bg_visible), 32'h1);

        // V4 transparency and disabled tile, back to back.
        drive(0, 640, 19); tick();
        drive(1, 50, 20); tick();
        chk("v4_addr_a", 32'(bg_ram_addr), 32'd43);
        drive(1, 66, 20); tick();
        chk("v4_addr_b", 32'(bg_ram_addr), 32'd44);
        drive(0, 0, 0); tick();
        chk("v4_sheet_a", 32'(sheet_addr), 32'h202);
        tick();
        chk("v4_sheet_b", 32'(sheet_addr), 32'hA22);
        tick();
        chk("v4_key_pv", 32'(pixel_valid), 32'h1);
        chk("v4_key_vis", 32'(bg_visible), 32'h0);
        chk("v4_key_rgb", 32'(rgb), 32'h0);
        tick();
        chk("v4_dis_pv", 32'(pixel_valid), 32'h1);
        chk("v4_dis_vis", 32'(bg_visible), 32'h0);
        chk("v4_dis_rgb", 32'(rgb), 32'h0);

        // V5 blanking latency: video_on falls at cycle N.
        drive(1, 100, 40); tick();
        drive(1, 101, 40); tick();
        drive(1, 102, 40); tick();
        drive(0, 103, 40);
        tick(); tick(); tick(); tick();
        chk("v5_pv_n4", 32'(pixel_valid), 32'h1);
        tick();
        chk("v5_pv_n5", 32'(pixel_valid), 32'h0);

        // V5 offset change mid-line waits for x==640.
        drive(1, 300, 40); bg_x_offset = 4'd9; tick();
        chk("v5_mid_a", 32'(bg_ram_addr), 32'd98);
        drive(1, 301, 40); tick();
        chk("v5_mid_b", 32'(bg_ram_addr), 32'd98);
        drive(0, 640, 40); tick();
        bg_x_offset = 4'd0;
        drive(1, 300, 41); tick();
        chk("v5_next_line", 32'(bg_ram_addr), 32'd99);

        // V6 reset mid-line.
        for (int i = 0; i < 6; i++) begin
            drive(1, 194 + i, 100);
            tick();
        end
        chk("v6_pre_pv", 32'(pixel_valid), 32'h1);
        reset = 1'b1;
        drive(1, 200, 100); tick();
        chk("v6_rst_pv", 32'(pixel_valid), 32'h0);
        chk("v6_rst_vis", 32'(bg_visible), 32'h0);
        chk("v6_rst_rgb", 32'(rgb), 32'h0);
        chk("v6_rst_addr", 32'(bg_ram_addr), 32'h0);
        chk("v6_rst_sheet", 32'(sheet_addr), 32'h0);
        reset = 1'b0;
        drive(0, 201, 100); tick();
        chk("v6_idle1_pv", 32'(pixel_valid), 32'h0);
        drive(0, 202, 100); tick();
        chk("v6_idle2_pv", 32'(pixel_valid), 32'h0);
        drive(1, 200, 100); tick();
        chk("v6_r1_addr", 32'(bg_ram_addr), 32'd252);
        chk("v6_r1_pv", 32'(pixel_valid), 32'h0);
        tick();
        chk("v6_r2_pv", 32'(pixel_valid), 32'h0);
        tick();
        chk("v6_r3_pv", 32'(pixel_valid), 32'h0);
        tick();
        chk("v6_r4_pv", 32'(pixel_valid), 32'h0);
        tick();
        chk("v6_r5_pv", 32'(pixel_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
